// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB line-side receive decoder.
package usb_rx_pkg;

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERR_WAIT} rx_state_t;
    typedef enum logic [1:0] {J, K, SE0} line_state_t;

    // SYNC 0000_0001 as it appears after LSB-first shift-in
    localparam logic [7:0]  SYNC_PATTERN   = 8'h80;
    localparam int unsigned STUFF_LIMIT    = 6;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

endpackage

// File: rtl/usb_rx_sampler.sv
// Synchronizes D+/D-, classifies the line state and recovers the per-bit sample strobe.
module usb_rx_sampler
    import usb_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dp_i,
    input  logic        dm_i,
    output logic        sample_strobe_o,
    output line_state_t line_state_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] PhaseHalf = CntW'(CLKS_PER_BIT / 2);
    localparam logic [CntW-1:0] PhaseLast = CntW'(CLKS_PER_BIT - 1);

    logic [1:0]      dp_sync_q, dm_sync_q;
    line_state_t     line_d, line_q;
    logic [CntW-1:0] phase_q, phase_d;
    logic            line_change;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dp_sync_q <= 2'b11;
            dm_sync_q <= 2'b00;
            line_q    <= J;
            phase_q   <= '0;
        end else begin
            dp_sync_q <= {dp_sync_q[0], dp_i};
            dm_sync_q <= {dm_sync_q[0], dm_i};
            line_q    <= line_d;
            phase_q   <= phase_d;
        end
    end

    // SE1 is folded into SE0
    always_comb begin
        if (dp_sync_q[1] && !dm_sync_q[1]) begin
            line_d = J;
        end else if (!dp_sync_q[1] && dm_sync_q[1]) begin
            line_d = K;
        end else begin
            line_d = SE0;
        end
    end

    assign line_change = (line_d != line_q);

    always_comb begin
        if (line_change || (phase_q == PhaseLast)) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + 1'b1;
        end
    end

    assign sample_strobe_o = (phase_q == PhaseHalf) && !line_change;
    assign line_state_o    = line_d;

endmodule

// File: rtl/usb_rx_decoder.sv
// USB receive decoder: NRZI decode, bit destuffing, SYNC/EOP detection and byte assembly.
// Optional CRC-16 residual check at EOP is enabled by defining USB_RX_CRC16_EN.
module usb_rx_decoder
    import usb_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned SE0_EOP_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_plus,
    input  logic       d_minus,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       rx_packet_start,
    output logic       rx_packet_end,
    output logic       rx_error,
    output logic       rx_busy
);

    logic        strobe;
    line_state_t line;

    usb_rx_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .clk_i          (clk),
        .rst_i          (rst),
        .dp_i           (d_plus),
        .dm_i           (d_minus),
        .sample_strobe_o(strobe),
        .line_state_o   (line)
    );

    rx_state_t   state_q, state_d;
    line_state_t ref_q, ref_d;
    logic [2:0]  ones_q, ones_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  sr_q, sr_d;
    logic [3:0]  se0_cnt_q, se0_cnt_d;
    logic        partial_q, partial_d;
    logic        seen_se0_q, seen_se0_d;
    logic        busy_q, busy_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d, start_q, start_d, end_q, end_d, err_q, err_d;
    logic        bit_val, crc_bad;
    logic [7:0]  shifted;

    assign bit_val = (line == ref_q);
    assign shifted = {bit_val, sr_q[7:1]};

`ifdef USB_RX_CRC16_EN
    logic [15:0] crc_q, crc_d;
    logic [1:0]  nbytes_q, nbytes_d;

    // Packets shorter than three bytes carry no CRC field
    assign crc_bad = (nbytes_q == 2'd3) && (crc_q != CRC16_RESIDUAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q    <= 16'hFFFF;
            nbytes_q <= 2'd0;
        end else begin
            crc_q    <= crc_d;
            nbytes_q <= nbytes_d;
        end
    end
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ref_q      <= J;
            ones_q     <= '0;
            bit_cnt_q  <= '0;
            sr_q       <= '0;
            se0_cnt_q  <= '0;
            partial_q  <= 1'b0;
            seen_se0_q <= 1'b0;
            busy_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            start_q    <= 1'b0;
            end_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ref_q      <= ref_d;
            ones_q     <= ones_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
            se0_cnt_q  <= se0_cnt_d;
            partial_q  <= partial_d;
            seen_se0_q <= seen_se0_d;
            busy_q     <= busy_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            start_q    <= start_d;
            end_q      <= end_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ref_d      = ref_q;
        ones_d     = ones_q;
        bit_cnt_d  = bit_cnt_q;
        sr_d       = sr_q;
        se0_cnt_d  = se0_cnt_q;
        partial_d  = partial_q;
        seen_se0_d = seen_se0_q;
        busy_d     = busy_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        start_d    = 1'b0;
        end_d      = 1'b0;
        err_d      = 1'b0;
`ifdef USB_RX_CRC16_EN
        crc_d      = crc_q;
        nbytes_d   = nbytes_q;
`endif
        if (strobe) begin
            unique case (state_q)
                IDLE: begin
                    ref_d = J;
                    if (line == K) begin
                        state_d   = SYNC;
                        ref_d     = K;
                        sr_d      = 8'h00;
                        bit_cnt_d = 4'd1;
                    end
                end
                SYNC: begin
                    if (line == SE0) begin
                        state_d = IDLE;
                    end else begin
                        ref_d     = line;
                        sr_d      = shifted;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (shifted == SYNC_PATTERN) begin
                                state_d   = DATA;
                                start_d   = 1'b1;
                                busy_d    = 1'b1;
                                bit_cnt_d = 4'd0;
                                // The trailing SYNC 1 counts toward the stuffing run
                                ones_d    = 3'd1;
`ifdef USB_RX_CRC16_EN
                                crc_d     = 16'hFFFF;
                                nbytes_d  = 2'd0;
`endif
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
                DATA: begin
                    if (line == SE0) begin
                        state_d   = EOP;
                        se0_cnt_d = 4'd1;
                        partial_d = (bit_cnt_q != 4'd0);
                    end else begin
                        ref_d = line;
                        if (ones_q == 3'(STUFF_LIMIT)) begin
                            ones_d = 3'd0;
                            if (bit_val) begin
                                err_d      = 1'b1;
                                state_d    = ERR_WAIT;
                                seen_se0_d = 1'b0;
                            end
                        end else begin
                            ones_d = bit_val ? ones_q + 3'd1 : 3'd0;
                            sr_d   = shifted;
`ifdef USB_RX_CRC16_EN
                            if (nbytes_q != 2'd0) begin
                                crc_d = {crc_q[14:0], 1'b0} ^
                                        ((bit_val ^ crc_q[15]) ? CRC16_POLY : 16'h0000);
                            end
`endif
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_d = 4'd0;
                                data_d    = shifted;
                                valid_d   = 1'b1;
`ifdef USB_RX_CRC16_EN
                                if (nbytes_q != 2'd3) nbytes_d = nbytes_q + 2'd1;
`endif
                            end else begin
                                bit_cnt_d = bit_cnt_q + 4'd1;
                            end
                        end
                    end
                end
                EOP: begin
                    if (line == SE0) begin
                        if (se0_cnt_q != 4'hF) se0_cnt_d = se0_cnt_q + 4'd1;
                    end else if ((line == J) && (se0_cnt_q >= 4'(SE0_EOP_BITS))) begin
                        state_d = IDLE;
                        ref_d   = J;
                        end_d   = 1'b1;
                        err_d   = partial_q || crc_bad;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = ERR_WAIT;
                        err_d      = 1'b1;
                        seen_se0_d = 1'b0;
                    end
                end
                ERR_WAIT: begin
                    seen_se0_d = (line == SE0);
                    if ((line == J) && seen_se0_q) begin
                        state_d = IDLE;
                        ref_d   = J;
                        busy_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rx_data         = data_q;
    assign rx_data_valid   = valid_q;
    assign rx_packet_start = start_q;
    assign rx_packet_end   = end_q;
    assign rx_error        = err_q;
    assign rx_busy         = busy_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Randomized self-checking bench for usb_rx_decoder against a packet-level reference model.
module tb_usb_rx_decoder;

    localparam int unsigned CPB  = 8;
    localparam int unsigned SE0B = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_plus, d_minus;
    logic [7:0] rx_data;
    logic       rx_data_valid, rx_packet_start, rx_packet_end, rx_error, rx_busy;

    usb_rx_decoder #(
        .CLKS_PER_BIT(CPB),
        .SE0_EOP_BITS(SE0B)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .d_plus         (d_plus),
        .d_minus        (d_minus),
        .rx_data        (rx_data),
        .rx_data_valid  (rx_data_valid),
        .rx_packet_start(rx_packet_start),
        .rx_packet_end  (rx_packet_end),
        .rx_error       (rx_error),
        .rx_busy        (rx_busy)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Event monitor, sampled on the falling edge
    int unsigned mon_start, mon_end, mon_err, mon_end_err, mon_valid_end, mon_busy;
    logic [7:0]  mon_bytes[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_data_valid) mon_bytes.push_back(rx_data);
            if (rx_packet_start) mon_start++;
            if (rx_packet_end) mon_end++;
            if (rx_error) mon_err++;
            if (rx_packet_end && rx_error) mon_end_err++;
            if (rx_data_valid && rx_packet_end) mon_valid_end++;
            if (rx_busy) mon_busy++;
        end
    end

    task automatic clear_mon();
        mon_start = 0; mon_end = 0; mon_err = 0; mon_end_err = 0;
        mon_valid_end = 0; mon_busy = 0;
        mon_bytes.delete();
    endtask

    logic [7:0] pkt[$];
    bit         tx_raw[$];
    logic [7:0] exp_bytes[$];
    int         exp_start, exp_end, exp_err, exp_end_err;
    bit         cur_j;

    task automatic drive_line(input logic dp, input logic dm, input int nbits);
        d_plus  = dp;
        d_minus = dm;
        repeat (nbits * CPB) @(negedge clk);
    endtask

    // NRZI: a 0 toggles the line, a 1 holds it
    task automatic send_bit(input bit b);
        if (!b) cur_j = !cur_j;
        drive_line(cur_j, !cur_j, 1);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    function automatic logic [15:0] crc16_of(input logic [7:0] q[$], input int first,
                                             input int last);
        logic [15:0] c;
        bit          fb;
        c = 16'hFFFF;
        for (int k = first; k <= last; k++) begin
            for (int i = 0; i < 8; i++) begin
                fb = q[k][i] ^ c[15];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8005;
            end
        end
        return c;
    endfunction

    // CRC field goes out complemented, high-order bit first
    task automatic append_crc();
        logic [15:0] x;
        logic [7:0]  a, b;
        x = ~crc16_of(pkt, 1, pkt.size() - 1);
        for (int i = 0; i < 8; i++) begin
            a[i] = x[15 - i];
            b[i] = x[7 - i];
        end
        pkt.push_back(a);
        pkt.push_back(b);
    endtask

    task automatic build_raw();
        int ones;
        tx_raw.delete();
        ones = 1;
        foreach (pkt[k]) begin
            for (int i = 0; i < 8; i++) begin
                tx_raw.push_back(pkt[k][i]);
                ones = pkt[k][i] ? ones + 1 : 0;
                if (ones == 6) begin
                    tx_raw.push_back(1'b0);
                    ones = 0;
                end
            end
        end
    endtask

    // Reference: destuff the raw bit list, collect bytes, decide the packet outcome
    task automatic model();
        int         ones, nbits;
        bit         stuff_err, bad;
        logic [7:0] cur;
        logic [15:0] x;
        exp_bytes.delete();
        ones = 1; nbits = 0; cur = '0; stuff_err = 0;
        for (int i = 0; i < tx_raw.size(); i++) begin
            if (ones == 6) begin
                if (tx_raw[i]) begin
                    stuff_err = 1;
                    break;
                end
                ones = 0;
            end else begin
                ones = tx_raw[i] ? ones + 1 : 0;
                cur[nbits] = tx_raw[i];
                nbits++;
                if (nbits == 8) begin
                    exp_bytes.push_back(cur);
                    nbits = 0;
                end
            end
        end
        exp_start = 1;
        if (stuff_err) begin
            exp_end = 0; exp_err = 1; exp_end_err = 0;
        end else begin
            bad = (nbits != 0);
`ifdef USB_RX_CRC16_EN
            if (exp_bytes.size() >= 3) begin
                x = ~crc16_of(exp_bytes, 1, exp_bytes.size() - 3);
                for (int i = 0; i < 8; i++) begin
                    if (exp_bytes[exp_bytes.size() - 2][i] != x[15 - i]) bad = 1;
                    if (exp_bytes[exp_bytes.size() - 1][i] != x[7 - i]) bad = 1;
                end
            end
`else
            x = 16'h0;
`endif
            exp_end = 1; exp_err = bad ? 1 : 0; exp_end_err = exp_err;
        end
    endtask

    task automatic transmit(input int se0_bits);
        cur_j = 1'b1;
        drive_line(1'b1, 1'b0, 3);
        send_sync();
        foreach (tx_raw[i]) send_bit(tx_raw[i]);
        drive_line(1'b0, 1'b0, se0_bits);
        cur_j = 1'b1;
        drive_line(1'b1, 1'b0, 4);
    endtask

    task automatic run_check(input string tag, input int se0_bits);
        clear_mon();
        model();
        transmit(se0_bits);
        check_eq({tag, "/start"}, mon_start, exp_start);
        check_eq({tag, "/nbytes"}, mon_bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < mon_bytes.size(); i++)
            check_eq({tag, "/byte"}, mon_bytes[i], exp_bytes[i]);
        check_eq({tag, "/end"}, mon_end, exp_end);
        check_eq({tag, "/err"}, mon_err, exp_err);
        check_eq({tag, "/end_err"}, mon_end_err, exp_end_err);
        check_eq({tag, "/valid_end"}, mon_valid_end, 0);
        check_eq({tag, "/busy_after"}, rx_busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1; d_plus = 1'b1; d_minus = 1'b0; cur_j = 1'b1;
        clear_mon();
        repeat (3) @(negedge clk);
        check_eq("reset/data", rx_data, 8'h00);
        check_eq("reset/valid", rx_data_valid, 1'b0);
        check_eq("reset/start", rx_packet_start, 1'b0);
        check_eq("reset/end", rx_packet_end, 1'b0);
        check_eq("reset/error", rx_error, 1'b0);
        check_eq("reset/busy", rx_busy, 1'b0);
        rst = 1'b0;
        drive_line(1'b1, 1'b0, 4);

        // PID only
        pkt = '{8'hC3};
        build_raw();
        run_check("pid_c3", 2);

        // Stuffing inside payload
        pkt = '{8'hC3, 8'hFF, 8'hFF};
`ifdef USB_RX_CRC16_EN
        append_crc();
`endif
        build_raw();
        run_check("stuff_ff", 2);

        // Seven 1s without a stuffed zero
        pkt = '{8'hC3};
        build_raw();
        for (int i = 0; i < 7; i++) tx_raw.push_back(1'b1);
        tx_raw.push_back(1'b0); tx_raw.push_back(1'b1); tx_raw.push_back(1'b0);
        run_check("stuff_viol", 2);

        // 12 data bits: one byte, then partial-byte error at EOP
        pkt = '{8'hC3};
        build_raw();
        for (int i = 0; i < 4; i++) tx_raw.push_back(1'($urandom_range(0, 1)));
        run_check("partial12", 2);

        // Noise K followed by a non-SYNC pattern
        clear_mon();
        cur_j = 1'b1;
        drive_line(1'b1, 1'b0, 3);
        for (int i = 0; i < 8; i++) send_bit(i[0]);
        drive_line(1'b1, 1'b0, 6);
        check_eq("noise/start", mon_start, 0);
        check_eq("noise/bytes", mon_bytes.size(), 0);
        check_eq("noise/end_err", mon_end + mon_err, 0);
        check_eq("noise/busy", mon_busy, 0);

`ifdef USB_RX_CRC16_EN
        pkt = '{8'hC3, 8'h00, 8'h01, 8'h02, 8'h03};
        append_crc();
        build_raw();
        run_check("crc_good", 2);
        pkt = '{8'hC3, 8'h00, 8'h01, 8'h02, 8'h03};
        append_crc();
        pkt[2] = pkt[2] ^ 8'h04;
        build_raw();
        run_check("crc_flip", 2);
`endif

        for (int n = 0; n < 16; n++) begin
            int len;
            len = $urandom_range(1, 5);
            pkt.delete();
            pkt.push_back(8'(($urandom_range(0, 15) << 4) | 4'hC));
            for (int i = 1; i < len; i++) pkt.push_back(8'($urandom));
`ifdef USB_RX_CRC16_EN
            append_crc();
            if ($urandom_range(0, 2) == 0) begin
                int k;
                k = $urandom_range(1, pkt.size() - 1);
                pkt[k] = pkt[k] ^ 8'(1 << $urandom_range(0, 7));
            end
`endif
            build_raw();
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < $urandom_range(1, 5); i++)
                    tx_raw.push_back(1'($urandom_range(0, 1)));
            run_check("random", $urandom_range(2, 3));
        end

        // Async reset in the middle of a packet
        clear_mon();
        cur_j = 1'b1;
        drive_line(1'b1, 1'b0, 3);
        send_sync();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst/busy", rx_busy, 1'b0);
        check_eq("midrst/valid", rx_data_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_mon();
        drive_line(1'b1, 1'b0, 6);
        check_eq("midrst/pulses", mon_start + mon_end + mon_err + mon_bytes.size(), 0);
        check_eq("midrst/busy_after", mon_busy, 0);

        // Decoder still receives after the abort
        pkt = '{8'h4B, 8'h5A};
`ifdef USB_RX_CRC16_EN
        append_crc();
`endif
        build_raw();
        run_check("post_rst", 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
